// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter for the common data bus.
// Grants at most one reservation station per cycle, broadcasts its tag, result and
// destination register, and returns a one-cycle Grant pulse (the station's Finished).
// Ports:
//   clock_i      system clock, rising edge
//   reset_i      synchronous active-high reset
//   req_i        per-station completed-result request
//   result_i     per-station result, station i at [i*DATA_W +: DATA_W]
//   r_target_i   per-station destination register, station i at [i*3 +: 3]
//   cdb_stall_i  bus blocked this cycle, no new grant
//   grant_o      one-hot grant pulse
//   cdb_valid_o  broadcast valid
//   cdb_tag_o    broadcasting station tag (i+1), 0 when idle
//   cdb_data_o   broadcast result, 0 when idle
//   cdb_rdest_o  broadcast destination register, 0 when idle
//   reg_we_o     register-file write enable
//   bcast_cnt_o  completed broadcast count, wraps
module cdb_arbiter #(
  parameter int unsigned N_RS   = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned TAG_W  = 3
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic [N_RS-1:0]          req_i,
  input  logic [N_RS*DATA_W-1:0]   result_i,
  input  logic [N_RS*3-1:0]        r_target_i,
  input  logic                     cdb_stall_i,
  output logic [N_RS-1:0]          grant_o,
  output logic                     cdb_valid_o,
  output logic [TAG_W-1:0]         cdb_tag_o,
  output logic [DATA_W-1:0]        cdb_data_o,
  output logic [2:0]               cdb_rdest_o,
  output logic                     reg_we_o,
  output logic [7:0]               bcast_cnt_o
);

  localparam int unsigned PTR_W = (N_RS > 1) ? $clog2(N_RS) : 1;
  localparam int unsigned RD_W  = 3;
  localparam int unsigned CNT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BCAST = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [N_RS-1:0]     grant_q, grant_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [RD_W-1:0]     rdest_q, rdest_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;

  logic [N_RS-1:0]     elig_c;
  logic [2*N_RS-1:0]   dbl_c;
  logic [N_RS-1:0]     rot_c;
  logic                found_c;
  logic [PTR_W-1:0]    win_c;
  logic                go_c;

  logic [DATA_W-1:0]   res_arr [N_RS];
  logic [RD_W-1:0]     tgt_arr [N_RS];

  // Unpack the flat per-station buses so the winner can index them directly.
  for (genvar i = 0; i < int'(N_RS); i++) begin : g_unpack
    assign res_arr[i] = result_i[i*DATA_W +: DATA_W];
    assign tgt_arr[i] = r_target_i[i*RD_W +: RD_W];
  end

  // Round-robin search: rotate the eligible vector so bit k is station (ptr+k) mod N_RS,
  // then take the lowest set bit. The station granted last cycle is masked out.
  always_comb begin
    elig_c  = req_i & ~grant_q;
    dbl_c   = {elig_c, elig_c} >> ptr_q;
    rot_c   = dbl_c[N_RS-1:0];
    found_c = 1'b0;
    win_c   = '0;
    for (int k = 0; k < int'(N_RS); k++) begin
      if (!found_c && rot_c[PTR_W'(k)]) begin
        found_c = 1'b1;
        win_c   = PTR_W'((int'(ptr_q) + k) % int'(N_RS));
      end
    end
    go_c = found_c & ~cdb_stall_i;
  end

  // Next-state and registered-output logic; idle values are the defaults.
  always_comb begin
    state_d = IDLE;
    grant_d = '0;
    tag_d   = '0;
    data_d  = '0;
    rdest_d = '0;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE:    if (go_c) state_d = BCAST;
      BCAST:   if (go_c) state_d = BCAST;
      default: state_d = IDLE;
    endcase
    if (go_c) begin
      grant_d = N_RS'(1) << win_c;
      tag_d   = TAG_W'(int'(win_c) + 1);
      data_d  = res_arr[win_c];
      rdest_d = tgt_arr[win_c];
      cnt_d   = cnt_q + CNT_W'(1);
      ptr_d   = PTR_W'((int'(win_c) + 1) % int'(N_RS));
    end
  end

  // State and output registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      rdest_q <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      rdest_q <= rdest_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant_o     = grant_q;
  assign cdb_valid_o = (state_q == BCAST);
  assign reg_we_o    = (state_q == BCAST);
  assign cdb_tag_o   = tag_q;
  assign cdb_data_o  = data_q;
  assign cdb_rdest_o = rdest_q;
  assign bcast_cnt_o = cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed vector table, random traffic against a
// behavioural reference model, counter wrap and reset during a broadcast.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req;
  logic [63:0]   res;
  logic [11:0]   tgt;
  logic          stall;
  logic [3:0]    grant;
  logic          valid;
  logic [2:0]    tag;
  logic [15:0]   data;
  logic [2:0]    rdest;
  logic          we;
  logic [7:0]    cnt;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: next search start, station granted on the outputs (-1 none),
  // broadcast count, and the outputs expected after the latest edge.
  int m_ptr = 0;
  int m_last = -1;
  int m_cnt = 0;
  logic [3:0]  e_grant;
  logic [2:0]  e_tag;
  logic [15:0] e_data;
  logic [2:0]  e_rdest;
  logic        e_valid;

  localparam logic [11:0] TGT_FIX = {3'd7, 3'd5, 3'd2, 3'd1};

  cdb_arbiter #(.N_RS(4), .DATA_W(16), .TAG_W(3)) dut (
    .clock_i     (clk),
    .reset_i     (rst),
    .req_i       (req),
    .result_i    (res),
    .r_target_i  (tgt),
    .cdb_stall_i (stall),
    .grant_o     (grant),
    .cdb_valid_o (valid),
    .cdb_tag_o   (tag),
    .cdb_data_o  (data),
    .cdb_rdest_o (rdest),
    .reg_we_o    (we),
    .bcast_cnt_o (cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // One clock: drive at the falling edge, advance the model, compare just after the rising edge.
  task automatic step(input logic r, input logic [3:0] rq, input logic st,
                      input logic [63:0] rs, input logic [11:0] tg);
    int win;
    @(negedge clk);
    rst = r; req = rq; stall = st; res = rs; tgt = tg;
    if (r) begin
      m_ptr = 0; m_last = -1; m_cnt = 0; win = -1;
    end else begin
      win = -1;
      if (!st) begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (m_ptr + k) % N;
          if (win < 0 && ((rq >> idx) & 4'd1) != 4'd0 && idx != m_last) win = idx;
        end
      end
    end
    if (win >= 0) begin
      e_grant = 4'(1 << win);
      e_tag   = 3'(win + 1);
      e_data  = 16'(rs >> (win * DW));
      e_rdest = 3'(tg >> (win * 3));
      e_valid = 1'b1;
      m_cnt   = (m_cnt + 1) % 256;
      m_ptr   = (win + 1) % N;
      m_last  = win;
    end else begin
      e_grant = '0; e_tag = '0; e_data = '0; e_rdest = '0; e_valid = 1'b0;
      m_last  = -1;
    end
    @(posedge clk);
    #1;
    chk("grant", 64'(grant), 64'(e_grant));
    chk("valid", 64'(valid), 64'(e_valid));
    chk("reg_we", 64'(we), 64'(e_valid));
    chk("tag", 64'(tag), 64'(e_tag));
    chk("data", 64'(data), 64'(e_data));
    chk("rdest", 64'(rdest), 64'(e_rdest));
    chk("bcast_cnt", 64'(cnt), 64'(m_cnt));
  endtask

  typedef struct {
    logic [3:0]  req;
    logic        stall;
    logic [15:0] res2;
    logic [3:0]  eg;
    logic [2:0]  etag;
    logic        ev;
    logic [7:0]  ecnt;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic [63:0] rs;
    int guard;
    rst = 1'b1; req = '0; stall = 1'b0; res = '0; tgt = TGT_FIX;

    tbl[0]  = '{4'b1111, 1'b0, 16'h2A2A, 4'b0001, 3'd1, 1'b1, 8'd1};
    tbl[1]  = '{4'b1111, 1'b0, 16'h2A2A, 4'b0010, 3'd2, 1'b1, 8'd2};
    tbl[2]  = '{4'b1111, 1'b0, 16'h2A2A, 4'b0100, 3'd3, 1'b1, 8'd3};
    tbl[3]  = '{4'b1111, 1'b0, 16'h2A2A, 4'b1000, 3'd4, 1'b1, 8'd4};
    tbl[4]  = '{4'b1111, 1'b0, 16'h2A2A, 4'b0001, 3'd1, 1'b1, 8'd5};
    tbl[5]  = '{4'b0100, 1'b0, 16'h00AB, 4'b0100, 3'd3, 1'b1, 8'd6};
    tbl[6]  = '{4'b0001, 1'b0, 16'h2A2A, 4'b0001, 3'd1, 1'b1, 8'd7};
    tbl[7]  = '{4'b0001, 1'b0, 16'h2A2A, 4'b0000, 3'd0, 1'b0, 8'd7};
    tbl[8]  = '{4'b0001, 1'b0, 16'h2A2A, 4'b0001, 3'd1, 1'b1, 8'd8};
    tbl[9]  = '{4'b0001, 1'b0, 16'h2A2A, 4'b0000, 3'd0, 1'b0, 8'd8};
    tbl[10] = '{4'b0110, 1'b1, 16'h2A2A, 4'b0000, 3'd0, 1'b0, 8'd8};
    tbl[11] = '{4'b0110, 1'b1, 16'h2A2A, 4'b0000, 3'd0, 1'b0, 8'd8};
    tbl[12] = '{4'b0110, 1'b1, 16'h2A2A, 4'b0000, 3'd0, 1'b0, 8'd8};
    tbl[13] = '{4'b0110, 1'b0, 16'h2A2A, 4'b0010, 3'd2, 1'b1, 8'd9};
    tbl[14] = '{4'b0110, 1'b0, 16'h2A2A, 4'b0100, 3'd3, 1'b1, 8'd10};
    tbl[15] = '{4'b0000, 1'b0, 16'h2A2A, 4'b0000, 3'd0, 1'b0, 8'd10};

    // Reset with every station requesting: all outputs stay zero.
    step(1'b1, 4'b1111, 1'b0, 64'h0, TGT_FIX);
    step(1'b1, 4'b1111, 1'b0, 64'h0, TGT_FIX);

    // Directed table.
    for (int i = 0; i < 16; i++) begin
      rs = {16'h4444, tbl[i].res2, 16'h2222, 16'h1111};
      step(1'b0, tbl[i].req, tbl[i].stall, rs, TGT_FIX);
      chk($sformatf("tbl%0d_grant", i), 64'(grant), 64'(tbl[i].eg));
      chk($sformatf("tbl%0d_tag", i), 64'(tag), 64'(tbl[i].etag));
      chk($sformatf("tbl%0d_valid", i), 64'(valid), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d_cnt", i), 64'(cnt), 64'(tbl[i].ecnt));
      if (i == 5) begin
        chk("tbl5_data", 64'(data), 64'h00AB);
        chk("tbl5_rdest", 64'(rdest), 64'd5);
      end
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rs = {$urandom, $urandom};
      step(1'b0, 4'($urandom), ($urandom % 5) == 0, rs, 12'($urandom));
    end

    // Drive the broadcast counter to 255, then wrap it.
    guard = 0;
    while (m_cnt != 255 && guard < 1000) begin
      step(1'b0, 4'b1111, 1'b0, {$urandom, $urandom}, TGT_FIX);
      guard++;
    end
    chk("cnt_at_255", 64'(cnt), 64'd255);
    step(1'b0, 4'b1111, 1'b0, 64'h0, TGT_FIX);
    chk("cnt_wrap", 64'(cnt), 64'd0);
    chk("wrap_valid", 64'(valid), 64'd1);

    // Reset while a broadcast is on the bus.
    step(1'b0, 4'b1111, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, TGT_FIX);
    chk("pre_rst_valid", 64'(valid), 64'd1);
    step(1'b1, 4'b1111, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, TGT_FIX);
    chk("rst_mid_grant", 64'(grant), 64'd0);
    chk("rst_mid_valid", 64'(valid), 64'd0);
    chk("rst_mid_cnt", 64'(cnt), 64'd0);
    // After release the search restarts at station 0.
    step(1'b0, 4'b1111, 1'b0, 64'h0, TGT_FIX);
    chk("post_rst_grant", 64'(grant), 64'b0001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
